// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: load-use, branch/jump flush,
// interrupt entry, and memory-wait with timeout to a sticky error state.
module pipe_hazard_ctrl #(
  parameter int WAIT_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        ex_branch_taken,
  input  logic        id_jump,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        irq,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_hold,
  output logic        memwb_bubble,
  output logic        epc_save,
  output logic        irq_ack,
  output logic        mem_err,
  output logic [2:0]  state,
  output logic [15:0] stall_cnt
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

  typedef enum logic [2:0] {
    RUN      = 3'b000,
    IRQ      = 3'b001,
    MEM_WAIT = 3'b010,
    ERR      = 3'b011
  } state_t;

  state_t         cur, nxt;
  logic [CW-1:0]  wait_cnt, wait_nxt;
  logic           mem_stall, load_use;

  assign mem_stall = mem_req && !mem_ready;
  assign load_use  = ex_memread && (ex_rd != 5'd0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
  assign state     = cur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur       <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      cur      <= nxt;
      wait_cnt <= wait_nxt;
      // Counts lost fetch cycles; an error freeze is not a stall.
      if (!pc_write && cur != ERR && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  always_comb begin
    nxt          = cur;
    wait_nxt     = wait_cnt;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_hold   = 1'b0;
    memwb_bubble = 1'b0;
    epc_save     = 1'b0;
    irq_ack      = 1'b0;
    mem_err      = 1'b0;

    case (cur)
      RUN: begin
        wait_nxt = '0;
        if (mem_stall) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          exmem_hold   = 1'b1;
          memwb_bubble = 1'b1;
          nxt          = MEM_WAIT;
          wait_nxt     = CW'(1);
        end else if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (irq) begin
          epc_save = 1'b1;
          pc_write = 1'b0;
          nxt      = IRQ;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end else if (id_jump) begin
          ifid_flush = 1'b1;
        end
      end
      IRQ: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        irq_ack    = 1'b1;
        nxt        = RUN;
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          exmem_hold   = 1'b1;
          memwb_bubble = 1'b1;
          if (wait_cnt == WAIT_LIM) nxt = ERR;
          else                      wait_nxt = wait_cnt + CW'(1);
        end else begin
          nxt      = RUN;
          wait_nxt = '0;
        end
      end
      ERR: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        exmem_hold   = 1'b1;
        memwb_bubble = 1'b1;
        mem_err      = 1'b1;
      end
      default: nxt = RUN;
    endcase

    // Reset drives a bubble into the front of the pipe regardless of state.
    if (!reset) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_hold   = 1'b0;
      memwb_bubble = 1'b1;
      epc_save     = 1'b0;
      irq_ack      = 1'b0;
      mem_err      = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; outputs checked #1 after each negedge.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        ex_memread, ex_branch_taken, id_jump, mem_req, mem_ready, irq;
  logic        pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold;
  logic        memwb_bubble, epc_save, irq_ack, mem_err;
  logic [2:0]  state;
  logic [15:0] stall_cnt;

  int vectors    = 0;
  int miscompares = 0;
  int exp_stall  = 0;

  // {pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, memwb_bubble, epc_save, irq_ack, mem_err}
  localparam logic [8:0] O_DEF  = 9'b110000000;
  localparam logic [8:0] O_RST  = 9'b001101000;
  localparam logic [8:0] O_MEM  = 9'b000011000;
  localparam logic [8:0] O_BR   = 9'b111100000;
  localparam logic [8:0] O_IRQ  = 9'b010000100;
  localparam logic [8:0] O_LU   = 9'b000100000;
  localparam logic [8:0] O_JMP  = 9'b111000000;
  localparam logic [8:0] O_IRQS = 9'b111100010;
  localparam logic [8:0] O_ERR  = 9'b000011001;

  logic [8:0] outs;
  assign outs = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold,
                 memwb_bubble, epc_save, irq_ack, mem_err};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.WAIT_MAX(8)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .id_jump(id_jump), .mem_req(mem_req), .mem_ready(mem_ready), .irq(irq),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_hold(exmem_hold), .memwb_bubble(memwb_bubble),
    .epc_save(epc_save), .irq_ack(irq_ack), .mem_err(mem_err),
    .state(state), .stall_cnt(stall_cnt)
  );

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0; ex_memread = 1'b0;
    ex_branch_taken = 1'b0; id_jump = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; irq = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    tick(); tick();
    #1;
    vectors++;
    if (outs !== O_RST) begin miscompares++; $display("FAIL reset_outs: got %b want %b", outs, O_RST); end
    vectors++;
    if (state !== 3'd0 || stall_cnt !== 16'd0) begin
      miscompares++; $display("FAIL reset_regs: got state=%0d stall=%0d want 0/0", state, stall_cnt);
    end
    tick(); reset = 1'b1; #1;
    vectors++;
    if (outs !== O_DEF) begin miscompares++; $display("FAIL run_default: got %b want %b", outs, O_DEF); end
  endtask

  task automatic test_load_use();
    tick(); ex_memread = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; #1;
    vectors++;
    if (outs !== O_LU) begin miscompares++; $display("FAIL load_use_rt: got %b want %b", outs, O_LU); end
    exp_stall++;
    tick(); ex_rd = 5'd0; id_rt = 5'd0; #1;
    vectors++;
    if (stall_cnt !== 16'(exp_stall)) begin miscompares++; $display("FAIL stall_after_lu: got %0d want %0d", stall_cnt, exp_stall); end
    vectors++;
    if (outs !== O_DEF) begin miscompares++; $display("FAIL load_use_r0: got %b want %b", outs, O_DEF); end
    tick(); ex_rd = 5'd7; id_rs = 5'd7; id_rt = 5'd3; #1;
    vectors++;
    if (outs !== O_LU) begin miscompares++; $display("FAIL load_use_rs: got %b want %b", outs, O_LU); end
    exp_stall++;
    tick(); ex_memread = 1'b0; #1;
    vectors++;
    if (outs !== O_DEF) begin miscompares++; $display("FAIL no_load_match: got %b want %b", outs, O_DEF); end
    vectors++;
    if (stall_cnt !== 16'(exp_stall)) begin miscompares++; $display("FAIL stall_after_lu2: got %0d want %0d", stall_cnt, exp_stall); end
    idle();
  endtask

  task automatic test_branch_jump();
    tick(); ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; #1;
    vectors++;
    if (outs !== O_BR) begin miscompares++; $display("FAIL branch_over_lu: got %b want %b", outs, O_BR); end
    tick(); ex_branch_taken = 1'b0; ex_memread = 1'b0; id_jump = 1'b1; #1;
    vectors++;
    if (outs !== O_JMP || state !== 3'd0) begin
      miscompares++; $display("FAIL jump: got %b st=%0d want %b st=0", outs, state, O_JMP);
    end
    tick(); ex_memread = 1'b1; #1;
    vectors++;
    if (outs !== O_LU) begin miscompares++; $display("FAIL lu_over_jump: got %b want %b", outs, O_LU); end
    exp_stall++;
    tick(); idle(); #1;
    vectors++;
    if (stall_cnt !== 16'(exp_stall)) begin miscompares++; $display("FAIL stall_after_branch: got %0d want %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_mem_wait();
    tick(); mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1; #1;
    vectors++;
    if (outs !== O_MEM || state !== 3'd0) begin
      miscompares++; $display("FAIL mem_stall_run: got %b st=%0d want %b st=0", outs, state, O_MEM);
    end
    exp_stall++;
    ex_branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      vectors++;
      if (outs !== O_MEM || state !== 3'd2) begin
        miscompares++; $display("FAIL mem_wait_%0d: got %b st=%0d want %b st=2", i, outs, state, O_MEM);
      end
      exp_stall++;
    end
    tick(); mem_ready = 1'b1; irq = 1'b1; #1;
    vectors++;
    if (outs !== O_DEF || state !== 3'd2) begin
      miscompares++; $display("FAIL mem_release: got %b st=%0d want %b st=2", outs, state, O_DEF);
    end
    tick(); idle(); #1;
    vectors++;
    if (state !== 3'd0 || stall_cnt !== 16'(exp_stall)) begin
      miscompares++; $display("FAIL mem_done: got st=%0d stall=%0d want st=0 stall=%0d", state, stall_cnt, exp_stall);
    end
  endtask

  task automatic test_irq();
    tick(); irq = 1'b1; #1;
    vectors++;
    if (outs !== O_IRQ || state !== 3'd0) begin
      miscompares++; $display("FAIL irq_c1: got %b st=%0d want %b st=0", outs, state, O_IRQ);
    end
    exp_stall++;
    tick(); #1;
    vectors++;
    if (outs !== O_IRQS || state !== 3'd1) begin
      miscompares++; $display("FAIL irq_c2: got %b st=%0d want %b st=1", outs, state, O_IRQS);
    end
    tick(); #1;
    vectors++;
    if (outs !== O_IRQ || state !== 3'd0) begin
      miscompares++; $display("FAIL irq_c3: got %b st=%0d want %b st=0", outs, state, O_IRQ);
    end
    exp_stall++;
    tick(); irq = 1'b0; #1;
    vectors++;
    if (outs !== O_IRQS) begin miscompares++; $display("FAIL irq_c4: got %b want %b", outs, O_IRQS); end
    tick(); irq = 1'b1; mem_req = 1'b1; mem_ready = 1'b0; #1;
    vectors++;
    if (outs !== O_MEM || state !== 3'd0) begin
      miscompares++; $display("FAIL irq_vs_mem: got %b st=%0d want %b st=0", outs, state, O_MEM);
    end
    exp_stall++;
    tick(); mem_ready = 1'b1; #1;
    vectors++;
    if (outs !== O_DEF || state !== 3'd2) begin
      miscompares++; $display("FAIL irq_in_wait: got %b st=%0d want %b st=2", outs, state, O_DEF);
    end
    tick(); idle(); #1;
    vectors++;
    if (state !== 3'd0 || stall_cnt !== 16'(exp_stall)) begin
      miscompares++; $display("FAIL irq_done: got st=%0d stall=%0d want st=0 stall=%0d", state, stall_cnt, exp_stall);
    end
  endtask

  task automatic test_err();
    tick(); mem_req = 1'b1; mem_ready = 1'b0; #1;
    exp_stall++;
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      vectors++;
      if (state !== 3'd2) begin miscompares++; $display("FAIL err_wait_%0d: got st=%0d want 2", i, state); end
      exp_stall++;
    end
    tick(); #1;
    vectors++;
    if (outs !== O_ERR || state !== 3'd3) begin
      miscompares++; $display("FAIL err_entry: got %b st=%0d want %b st=3", outs, state, O_ERR);
    end
    mem_req = 1'b0; mem_ready = 1'b1;
    tick(); tick(); tick(); #1;
    vectors++;
    if (outs !== O_ERR || state !== 3'd3) begin
      miscompares++; $display("FAIL err_sticky: got %b st=%0d want %b st=3", outs, state, O_ERR);
    end
    vectors++;
    if (stall_cnt !== 16'(exp_stall)) begin miscompares++; $display("FAIL err_stall: got %0d want %0d", stall_cnt, exp_stall); end
    tick(); reset = 1'b0; #1;
    vectors++;
    if (outs !== O_RST || state !== 3'd0 || stall_cnt !== 16'd0) begin
      miscompares++; $display("FAIL err_reset: got %b st=%0d stall=%0d want %b st=0 stall=0", outs, state, stall_cnt, O_RST);
    end
    exp_stall = 0;
    tick(); reset = 1'b1; idle(); #1;
    vectors++;
    if (outs !== O_DEF || state !== 3'd0) begin
      miscompares++; $display("FAIL err_release: got %b st=%0d want %b st=0", outs, state, O_DEF);
    end
  endtask

  task automatic test_reset_mid_wait();
    tick(); mem_req = 1'b1; mem_ready = 1'b0;
    tick(); tick(); #1;
    vectors++;
    if (state !== 3'd2) begin miscompares++; $display("FAIL rmw_enter: got st=%0d want 2", state); end
    reset = 1'b0; #1;
    vectors++;
    if (state !== 3'd0 || stall_cnt !== 16'd0 || outs !== O_RST) begin
      miscompares++; $display("FAIL rmw_reset: got st=%0d stall=%0d outs=%b want 0/0/%b", state, stall_cnt, outs, O_RST);
    end
    tick(); reset = 1'b1; idle(); #1;
    tick(); #1;
    vectors++;
    if (outs !== O_DEF || state !== 3'd0 || stall_cnt !== 16'd0) begin
      miscompares++; $display("FAIL rmw_release: got %b st=%0d stall=%0d want %b st=0 stall=0", outs, state, stall_cnt, O_DEF);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_jump();
    test_mem_wait();
    test_irq();
    test_err();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
